id_branch_unit: RTL and testbench
=================================

# id_branch_unit

Decode-stage control and branch-resolution block for the five-stage RV32I pipeline. It turns the IF/ID instruction into the control word and applies the hazard-bubble override. It compares the forwarded operands, computes the next-PC target and select, and raises flush and halt. Decode, compare and resolve are combinational; only the optional branch statistics counters are clocked.

## Interface
- No parameters; data width fixed at 32 bits.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `instr_i` in 32: instruction from IF/ID.
- `pc_i` in 32: PC of `instr_i`.
- `rs1_val_i`, `rs2_val_i` in 32: operands, already forwarded.
- `br_pred_i` in 1: IF predicted taken.
- `bubble_i` in 1: hazard unit requests a NOP.
- `stall_i` in 1: ID holds this cycle; counters do not advance.
- `ctrl_o` out `rv32i_control_word`: control word after the bubble override.
- `br_en_o` out 1: comparator result.
- `target_o` out 32: resolved next PC.
- `pcmux_sel_o` out 2: `pcmux_sel_t`.
- `flush_o` out 1: misprediction; flush IF/ID.
- `halt_o` out 1: taken branch to itself.
- `stat_{br,jal,jalr}_o` out 32 each: executed counts.
- `stat_{br,jal,jalr}_miss_o` out 32 each: flush counts.

## Operation
- **Immediates (sign-extended)**
  - i = instr[31:20]
  - s = {instr[31:25], instr[11:7]}
  - b = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - u = {instr[31:12], 12'h0}
  - j = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- **Control word defaults**: all fields zero, `opcode` = instr[6:0].
  - lui: load_regfile, regfilemux=u_imm.
  - auipc: alu add, pc + u_imm.
  - jal / jalr: load_regfile, regfilemux=pc_plus4.
  - br: cmpop=funct3.
  - load: add rs1 + i_imm, mem_read, regfilemux per funct3 (lb/lh/lw/lbu/lhu).
  - store: add rs1 + s_imm, mem_write, mem_byte_en sb=0001, sh=0011, sw=1111.
  - op-imm: aluop=funct3, srai when funct7[5]; slti/sltiu use cmpop blt/bltu, cmpmux=i_imm, regfilemux=br_en.
  - op-reg: add/sub and srl/sra chosen by funct7[5]; slt/sltu use cmpmux=rs2, regfilemux=br_en.
  - All other opcodes get defaults.
- **Bubble** (`bubble_i`=1): opcode forced to op_csr (7'h73), load_regfile=0, mem_read=0, mem_write=0, mem_byte_en=0, regfilemux=alu_out, alumux1=rs1, alumux2=rs2, pcmux_sel=pc_plus4.
- **Comparator**
  - Compares rs1 against `cmpmux ? i_imm : rs2`.
  - cmpop encodings: beq 000, bne 001, blt 100, bge 101, bltu 110, bgeu 111.
  - Undefined cmpop gives br_en=0.
- **Resolver** (raw opcode)
  - br taken: target = pc + b_imm, sel = br_target (01).
  - jal: target = pc + j_imm, sel = br_target (01).
  - jalr: target = (rs1 + i_imm) & ~1, sel = jalr_target (10).
  - Otherwise: target = pc + 4, sel = pc_plus4 (00).
  - All adds wrap modulo 2^32.
- **Flush** (post-bubble opcode)
  - br: br_en ≠ br_pred_i.
  - jal or jalr: ~br_pred_i.
  - Any other opcode, including a bubble: 0.
- **Halt**: `halt_o` = post-bubble opcode is br & br_en & target == pc & ~rst.

## Timing
- Every output except `stat_*` is combinational and settles in the same cycle; latency 0.
- Counters update on posedge `clk`. On each edge where `rst`=0 and `stall_i`=0:
  - +1 to the br/jal/jalr count matching the post-bubble opcode.
  - +1 to the matching miss count when that class flushed.
- `rst`=1 at an edge: all counters go to 0; reset takes priority over counting.
- Counters wrap at 2^32.
- A bubble counts nothing.

## Configuration
- Feature macro: `ID_BRANCH_STATS_EN`.
- Defined: counters are built as described above.
- Undefined: no counter flops; all `stat_*` outputs tied to 0.
- Combinational behaviour is identical either way.

## Structure
- Package `rv32i_types` holds:
  - `rv32i_opcode`, `branch_funct3_t`, `alu_ops`.
  - `rv32i_control_word`.
  - Mux select enums: pcmux, cmpmux, alumux, regfilemux.
- Sub-module `branch_cmp`: the comparator alone (cmpop, a, b → br_en).
- Decode, bubble override, resolver and counters live in `id_branch_unit`.

## Test plan
- **Taken beq mispredicted**: beq x1,x2,+16 at pc=0x100, rs1=rs2=5, pred=0 → br_en=1, target=0x110, sel=01, flush=1; next edge stat_br=1, stat_br_miss=1.
- **Not-taken blt predicted not taken**: blt with rs1=-1, rs2=-2, pred=0 → br_en=0, target=0x104, sel=00, flush=0.
- **Signed vs unsigned**: bltu with rs1=0xFFFFFFFF, rs2=1 → br_en=0; same operands with blt → br_en=1.
- **jalr**: jalr with rs1=0x203, i_imm=4, pred=1 → target=0x206, sel=10, flush=0; with pred=0 → flush=1.
- **Halt**: beq x0,x0,0 → halt=1. With rst=1 → halt=0. With bubble_i=1 → halt=0, flush=0, load_regfile=0, opcode=0x73.
- **Stall and reset**: stall_i=1 on a jal for 3 cycles → stat_jal unchanged. Then rst=1 for one edge → all stat_* = 0.

Source files
------------

// File: rtl/id_branch_unit_pkg.sv
// rv32i_types: opcode, funct3, ALU-op and mux-select encodings plus the
// decode-stage control word shared by the ID branch unit and its neighbours.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    f3_add  = 3'b000,
    f3_sll  = 3'b001,
    f3_slt  = 3'b010,
    f3_sltu = 3'b011,
    f3_xor  = 3'b100,
    f3_sr   = 3'b101,
    f3_or   = 3'b110,
    f3_and  = 3'b111
  } arith_funct3_t;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [1:0] {
    pcmux_pc_plus4    = 2'b00,
    pcmux_br_target   = 2'b01,
    pcmux_jalr_target = 2'b10
  } pcmux_sel_t;

  typedef enum logic {
    cmpmux_rs2   = 1'b0,
    cmpmux_i_imm = 1'b1
  } cmpmux_sel_t;

  typedef enum logic {
    alumux1_rs1 = 1'b0,
    alumux1_pc  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    alumux2_i_imm = 3'd0,
    alumux2_u_imm = 3'd1,
    alumux2_b_imm = 3'd2,
    alumux2_s_imm = 3'd3,
    alumux2_j_imm = 3'd4,
    alumux2_rs2   = 3'd5
  } alumux2_sel_t;

  typedef enum logic [3:0] {
    rf_alu_out  = 4'd0,
    rf_br_en    = 4'd1,
    rf_u_imm    = 4'd2,
    rf_lw       = 4'd3,
    rf_pc_plus4 = 4'd4,
    rf_lb       = 4'd5,
    rf_lbu      = 4'd6,
    rf_lh       = 4'd7,
    rf_lhu      = 4'd8
  } regfilemux_sel_t;

  // opcode and cmpop stay plain vectors: they carry raw instruction bits,
  // which may be values outside the enums above.
  typedef struct packed {
    logic [6:0]      opcode;
    alu_ops          aluop;
    logic [2:0]      cmpop;
    cmpmux_sel_t     cmpmux_sel;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    pcmux_sel_t      pcmux_sel;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic [3:0]      mem_byte_en;
  } rv32i_control_word;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/id_branch_unit_if.sv
// id_branch_unit_if: IF/ID operands in, control word, next-PC and branch
// statistics out. The slave modport is the branch unit's view.
interface id_branch_unit_if;
  import rv32i_types::*;

  logic [31:0]       instr_i;
  logic [31:0]       pc_i;
  logic [31:0]       rs1_val_i;
  logic [31:0]       rs2_val_i;
  logic              br_pred_i;
  logic              bubble_i;
  logic              stall_i;

  rv32i_control_word ctrl_o;
  logic              br_en_o;
  logic [31:0]       target_o;
  pcmux_sel_t        pcmux_sel_o;
  logic              flush_o;
  logic              halt_o;
  logic [31:0]       stat_br_o;
  logic [31:0]       stat_jal_o;
  logic [31:0]       stat_jalr_o;
  logic [31:0]       stat_br_miss_o;
  logic [31:0]       stat_jal_miss_o;
  logic [31:0]       stat_jalr_miss_o;

  modport master (
    output instr_i, pc_i, rs1_val_i, rs2_val_i, br_pred_i, bubble_i, stall_i,
    input  ctrl_o, br_en_o, target_o, pcmux_sel_o, flush_o, halt_o,
    input  stat_br_o, stat_jal_o, stat_jalr_o,
    input  stat_br_miss_o, stat_jal_miss_o, stat_jalr_miss_o
  );

  modport slave (
    input  instr_i, pc_i, rs1_val_i, rs2_val_i, br_pred_i, bubble_i, stall_i,
    output ctrl_o, br_en_o, target_o, pcmux_sel_o, flush_o, halt_o,
    output stat_br_o, stat_jal_o, stat_jalr_o,
    output stat_br_miss_o, stat_jal_miss_o, stat_jalr_miss_o
  );

endinterface

// File: rtl/id_branch_unit_branch_cmp.sv
// branch_cmp: pure comparator. Undefined cmpop encodings (010, 011) never
// report a taken condition.
module branch_cmp
  import rv32i_types::*;
(
  input  logic [2:0]  cmpop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        br_en
);

  // Evaluate the selected relation between a and b
  always_comb begin
    case (cmpop)
      beq:     br_en = (a == b);
      bne:     br_en = (a != b);
      blt:     br_en = ($signed(a) <  $signed(b));
      bge:     br_en = ($signed(a) >= $signed(b));
      bltu:    br_en = (a <  b);
      bgeu:    br_en = (a >= b);
      default: br_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_branch_unit.sv
// id_branch_unit: ID-stage decode, bubble override, branch compare and
// next-PC resolution. All of that is combinational; the only state is the
// optional branch statistics, built when ID_BRANCH_STATS_EN is defined and
// otherwise tied to zero.
module id_branch_unit
  import rv32i_types::*;
(
  input  logic            clk,
  input  logic            rst,
  id_branch_unit_if.slave bus
);

  logic [31:0]       instr;
  logic [31:0]       pc;
  logic [31:0]       rs1;
  logic [31:0]       rs2;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic [31:0]       i_imm;
  logic [31:0]       s_imm;
  logic [31:0]       b_imm;
  logic [31:0]       u_imm;
  logic [31:0]       j_imm;
  rv32i_control_word ctrl_dec;
  rv32i_control_word ctrl;
  logic [31:0]       cmp_b;
  logic              br_en;
  logic [31:0]       target;
  pcmux_sel_t        pcmux_sel;
  logic              flush;
  logic              halt;

  assign instr    = bus.instr_i;
  assign pc       = bus.pc_i;
  assign rs1      = bus.rs1_val_i;
  assign rs2      = bus.rs2_val_i;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];

  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'h000};
  assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Decode the raw instruction into a control word
  always_comb begin
    ctrl_dec        = '0;
    ctrl_dec.opcode = opcode;
    case (opcode)
      op_lui: begin
        ctrl_dec.load_regfile   = 1'b1;
        ctrl_dec.regfilemux_sel = rf_u_imm;
      end
      op_auipc: begin
        ctrl_dec.aluop        = alu_add;
        ctrl_dec.alumux1_sel  = alumux1_pc;
        ctrl_dec.alumux2_sel  = alumux2_u_imm;
        ctrl_dec.load_regfile = 1'b1;
      end
      op_jal, op_jalr: begin
        ctrl_dec.load_regfile   = 1'b1;
        ctrl_dec.regfilemux_sel = rf_pc_plus4;
      end
      op_br: begin
        ctrl_dec.cmpop = funct3;
      end
      op_load: begin
        ctrl_dec.aluop        = alu_add;
        ctrl_dec.alumux2_sel  = alumux2_i_imm;
        ctrl_dec.mem_read     = 1'b1;
        ctrl_dec.load_regfile = 1'b1;
        case (funct3)
          3'b000:  ctrl_dec.regfilemux_sel = rf_lb;
          3'b001:  ctrl_dec.regfilemux_sel = rf_lh;
          3'b010:  ctrl_dec.regfilemux_sel = rf_lw;
          3'b100:  ctrl_dec.regfilemux_sel = rf_lbu;
          3'b101:  ctrl_dec.regfilemux_sel = rf_lhu;
          default: ctrl_dec.regfilemux_sel = rf_alu_out;
        endcase
      end
      op_store: begin
        ctrl_dec.aluop       = alu_add;
        ctrl_dec.alumux2_sel = alumux2_s_imm;
        ctrl_dec.mem_write   = 1'b1;
        case (funct3)
          3'b000:  ctrl_dec.mem_byte_en = 4'b0001;
          3'b001:  ctrl_dec.mem_byte_en = 4'b0011;
          3'b010:  ctrl_dec.mem_byte_en = 4'b1111;
          default: ctrl_dec.mem_byte_en = 4'b0000;
        endcase
      end
      op_imm: begin
        ctrl_dec.aluop        = alu_ops'(funct3);
        ctrl_dec.alumux2_sel  = alumux2_i_imm;
        ctrl_dec.load_regfile = 1'b1;
        case (funct3)
          f3_sr: begin
            if (funct7_5) ctrl_dec.aluop = alu_sra;
          end
          f3_slt: begin
            ctrl_dec.cmpop          = blt;
            ctrl_dec.cmpmux_sel     = cmpmux_i_imm;
            ctrl_dec.regfilemux_sel = rf_br_en;
          end
          f3_sltu: begin
            ctrl_dec.cmpop          = bltu;
            ctrl_dec.cmpmux_sel     = cmpmux_i_imm;
            ctrl_dec.regfilemux_sel = rf_br_en;
          end
          default: ;
        endcase
      end
      op_reg: begin
        ctrl_dec.aluop        = alu_ops'(funct3);
        ctrl_dec.alumux2_sel  = alumux2_rs2;
        ctrl_dec.load_regfile = 1'b1;
        case (funct3)
          f3_add: begin
            if (funct7_5) ctrl_dec.aluop = alu_sub;
          end
          f3_sr: begin
            if (funct7_5) ctrl_dec.aluop = alu_sra;
          end
          f3_slt: begin
            ctrl_dec.cmpop          = blt;
            ctrl_dec.cmpmux_sel     = cmpmux_rs2;
            ctrl_dec.regfilemux_sel = rf_br_en;
          end
          f3_sltu: begin
            ctrl_dec.cmpop          = bltu;
            ctrl_dec.cmpmux_sel     = cmpmux_rs2;
            ctrl_dec.regfilemux_sel = rf_br_en;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Replace the decoded word with a side-effect-free NOP when bubbling
  always_comb begin
    ctrl = ctrl_dec;
    if (bus.bubble_i) begin
      ctrl.opcode         = op_csr;
      ctrl.load_regfile   = 1'b0;
      ctrl.mem_read       = 1'b0;
      ctrl.mem_write      = 1'b0;
      ctrl.mem_byte_en    = 4'b0000;
      ctrl.regfilemux_sel = rf_alu_out;
      ctrl.alumux1_sel    = alumux1_rs1;
      ctrl.alumux2_sel    = alumux2_rs2;
      ctrl.pcmux_sel      = pcmux_pc_plus4;
    end
  end

  assign cmp_b = (ctrl.cmpmux_sel == cmpmux_i_imm) ? i_imm : rs2;

  branch_cmp u_cmp (
    .cmpop (ctrl.cmpop),
    .a     (rs1),
    .b     (cmp_b),
    .br_en (br_en)
  );

  // Next PC follows the raw opcode so a bubbled slot still steers fetch
  always_comb begin
    target    = pc + PC_STEP;
    pcmux_sel = pcmux_pc_plus4;
    case (opcode)
      op_br: begin
        if (br_en) begin
          target    = pc + b_imm;
          pcmux_sel = pcmux_br_target;
        end
      end
      op_jal: begin
        target    = pc + j_imm;
        pcmux_sel = pcmux_br_target;
      end
      op_jalr: begin
        target    = (rs1 + i_imm) & 32'hFFFF_FFFE;
        pcmux_sel = pcmux_jalr_target;
      end
      default: ;
    endcase
  end

  // Flag a misprediction against the IF guess; bubbles never flush
  always_comb begin
    flush = 1'b0;
    case (ctrl.opcode)
      op_br:           flush = br_en ^ bus.br_pred_i;
      op_jal, op_jalr: flush = ~bus.br_pred_i;
      default: ;
    endcase
  end

  assign halt = (ctrl.opcode == op_br) && br_en && (target == pc) && !rst;

  assign bus.ctrl_o      = ctrl;
  assign bus.br_en_o     = br_en;
  assign bus.target_o    = target;
  assign bus.pcmux_sel_o = pcmux_sel;
  assign bus.flush_o     = flush;
  assign bus.halt_o      = halt;

`ifdef ID_BRANCH_STATS_EN
  logic        is_br;
  logic        is_jal;
  logic        is_jalr;
  logic [31:0] cnt_br;
  logic [31:0] cnt_jal;
  logic [31:0] cnt_jalr;
  logic [31:0] miss_br;
  logic [31:0] miss_jal;
  logic [31:0] miss_jalr;

  assign is_br   = (ctrl.opcode == op_br);
  assign is_jal  = (ctrl.opcode == op_jal);
  assign is_jalr = (ctrl.opcode == op_jalr);

  // Tally executed and flushed transfers; reset wins, stall freezes
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_br    <= '0;
      cnt_jal   <= '0;
      cnt_jalr  <= '0;
      miss_br   <= '0;
      miss_jal  <= '0;
      miss_jalr <= '0;
    end else if (!bus.stall_i) begin
      if (is_br)             cnt_br    <= cnt_br + 32'd1;
      if (is_jal)            cnt_jal   <= cnt_jal + 32'd1;
      if (is_jalr)           cnt_jalr  <= cnt_jalr + 32'd1;
      if (is_br && flush)    miss_br   <= miss_br + 32'd1;
      if (is_jal && flush)   miss_jal  <= miss_jal + 32'd1;
      if (is_jalr && flush)  miss_jalr <= miss_jalr + 32'd1;
    end
  end

  assign bus.stat_br_o        = cnt_br;
  assign bus.stat_jal_o       = cnt_jal;
  assign bus.stat_jalr_o      = cnt_jalr;
  assign bus.stat_br_miss_o   = miss_br;
  assign bus.stat_jal_miss_o  = miss_jal;
  assign bus.stat_jalr_miss_o = miss_jalr;
`else
  // Without statistics the clock and stall have no consumer here.
  logic unused_stats;
  assign unused_stats = ^{clk, bus.stall_i};

  assign bus.stat_br_o        = '0;
  assign bus.stat_jal_o       = '0;
  assign bus.stat_jalr_o      = '0;
  assign bus.stat_br_miss_o   = '0;
  assign bus.stat_jal_miss_o  = '0;
  assign bus.stat_jalr_miss_o = '0;
`endif

endmodule

// File: tb/tb_id_branch_unit.sv
// tb_id_branch_unit: directed and random vectors for the ID branch unit.
// Expected outputs are queued when a vector is applied and popped once the
// combinational outputs have settled; counter expectations come from a
// bench-side tally (zero when ID_BRANCH_STATS_EN is undefined).
module tb_id_branch_unit;
  import rv32i_types::*;

`ifdef ID_BRANCH_STATS_EN
  localparam logic STATS_ON = 1'b1;
`else
  localparam logic STATS_ON = 1'b0;
`endif

  typedef struct {
    logic        br_en;
    logic [31:0] target;
    logic [1:0]  sel;
    logic        flush;
    logic        halt;
    logic        lr;
    logic [6:0]  opcode;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_branch_unit_if bus ();

  id_branch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] m_br, m_jal, m_jalr, m_br_miss, m_jal_miss, m_jalr_miss;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // off is the branch offset in half-words
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [12:1] off);
    return {off[12], off[10:5], r2, r1, f3, off[4:1], off[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:1] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] r1,
                                       input logic [11:0] imm);
    return {imm, r1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [11:0] imm);
    return {imm[11:5], r2, r1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] stat_exp(input logic [31:0] m);
    return STATS_ON ? m : 32'd0;
  endfunction

  task automatic check_outputs(input string tag);
    exp_t e;
    check_val({tag, ".sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val({tag, ".br_en"},  32'(bus.br_en_o), 32'(e.br_en));
      check_val({tag, ".target"}, bus.target_o, e.target);
      check_val({tag, ".sel"},    32'(bus.pcmux_sel_o), 32'(e.sel));
      check_val({tag, ".flush"},  32'(bus.flush_o), 32'(e.flush));
      check_val({tag, ".halt"},   32'(bus.halt_o), 32'(e.halt));
      check_val({tag, ".opcode"}, 32'(bus.ctrl_o.opcode), 32'(e.opcode));
      check_val({tag, ".load_regfile"}, 32'(bus.ctrl_o.load_regfile), 32'(e.lr));
    end
    check_val({tag, ".stat_br"},        bus.stat_br_o,        stat_exp(m_br));
    check_val({tag, ".stat_jal"},       bus.stat_jal_o,       stat_exp(m_jal));
    check_val({tag, ".stat_jalr"},      bus.stat_jalr_o,      stat_exp(m_jalr));
    check_val({tag, ".stat_br_miss"},   bus.stat_br_miss_o,   stat_exp(m_br_miss));
    check_val({tag, ".stat_jal_miss"},  bus.stat_jal_miss_o,  stat_exp(m_jal_miss));
    check_val({tag, ".stat_jalr_miss"}, bus.stat_jalr_miss_o, stat_exp(m_jalr_miss));
  endtask

  task automatic run_vec(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic pred, input logic bub, input logic stl, input logic rs,
                         input logic e_br_en, input logic [31:0] e_tgt, input logic [1:0] e_sel,
                         input logic e_flush, input logic e_halt, input logic e_lr);
    exp_t e;
    @(negedge clk);
    bus.instr_i   = instr;
    bus.pc_i      = pc;
    bus.rs1_val_i = a;
    bus.rs2_val_i = b;
    bus.br_pred_i = pred;
    bus.bubble_i  = bub;
    bus.stall_i   = stl;
    rst           = rs;
    e.br_en  = e_br_en;
    e.target = e_tgt;
    e.sel    = e_sel;
    e.flush  = e_flush;
    e.halt   = e_halt;
    e.lr     = e_lr;
    e.opcode = bub ? 7'h73 : instr[6:0];
    sb_q.push_back(e);
    #1;
    check_outputs(tag);
    // account for what the coming edge should record
    if (rs) begin
      m_br = 0; m_jal = 0; m_jalr = 0;
      m_br_miss = 0; m_jal_miss = 0; m_jalr_miss = 0;
    end else if (!stl && !bub) begin
      case (instr[6:0])
        7'h63: begin m_br++;   if (e_flush) m_br_miss++;   end
        7'h6f: begin m_jal++;  if (e_flush) m_jal_miss++;  end
        7'h67: begin m_jalr++; if (e_flush) m_jalr_miss++; end
        default: ;
      endcase
    end
  endtask

  logic [2:0]  r_f3;
  logic [31:0] r_a, r_b, r_pc, r_tgt;
  logic        r_pred, r_tk;

  initial begin
    rst           = 1'b1;
    bus.instr_i   = '0;
    bus.pc_i      = '0;
    bus.rs1_val_i = '0;
    bus.rs2_val_i = '0;
    bus.br_pred_i = 1'b0;
    bus.bubble_i  = 1'b0;
    bus.stall_i   = 1'b0;
    m_br = 0; m_jal = 0; m_jalr = 0;
    m_br_miss = 0; m_jal_miss = 0; m_jalr_miss = 0;
    repeat (2) @(posedge clk);

    //      tag                 instr                                          pc         rs1           rs2           prd   bub   stl   rst   br_en  target       sel    flush halt  lr
    run_vec("beq_taken_miss",   enc_b(3'b000, 5'd1, 5'd2, 12'd8),             32'h100,   32'd5,        32'd5,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h110,     2'b01, 1'b1, 1'b0, 1'b0);
    run_vec("blt_not_taken",    enc_b(3'b100, 5'd1, 5'd2, 12'd8),             32'h100,   32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104,     2'b00, 1'b0, 1'b0, 1'b0);
    run_vec("bltu_unsigned",    enc_b(3'b110, 5'd1, 5'd2, 12'd8),             32'h100,   32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104,     2'b00, 1'b0, 1'b0, 1'b0);
    run_vec("blt_signed",       enc_b(3'b100, 5'd1, 5'd2, 12'd8),             32'h100,   32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h110,     2'b01, 1'b0, 1'b0, 1'b0);
    run_vec("jalr_pred",        enc_i(7'h67, 3'b000, 5'd1, 5'd5, 12'd4),      32'h100,   32'h203,      32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h206,     2'b10, 1'b0, 1'b0, 1'b1);
    run_vec("jalr_miss",        enc_i(7'h67, 3'b000, 5'd1, 5'd5, 12'd4),      32'h100,   32'h203,      32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h206,     2'b10, 1'b1, 1'b0, 1'b1);
    run_vec("jal_pred",         enc_j(5'd1, 20'hFFFFC),                       32'h200,   32'd0,        32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1F8,     2'b01, 1'b0, 1'b0, 1'b1);
    run_vec("jal_miss",         enc_j(5'd1, 20'hFFFFC),                       32'h200,   32'd0,        32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1F8,     2'b01, 1'b1, 1'b0, 1'b1);
    run_vec("slti_signed",      enc_i(7'h13, 3'b010, 5'd1, 5'd2, 12'd5),      32'h100,   32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h104,     2'b00, 1'b0, 1'b0, 1'b1);
    run_vec("sltiu_unsigned",   enc_i(7'h13, 3'b011, 5'd1, 5'd2, 12'd5),      32'h100,   32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104,     2'b00, 1'b0, 1'b0, 1'b1);
    run_vec("halt_self",        enc_b(3'b000, 5'd0, 5'd0, 12'd0),             32'h300,   32'd0,        32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300,     2'b01, 1'b0, 1'b1, 1'b0);
    run_vec("halt_bubble",      enc_b(3'b000, 5'd0, 5'd0, 12'd0),             32'h300,   32'd0,        32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300,     2'b01, 1'b0, 1'b0, 1'b0);
    check_val("bubble.mem_byte_en", 32'(bus.ctrl_o.mem_byte_en), 32'd0);
    check_val("bubble.alumux2", 32'(bus.ctrl_o.alumux2_sel), 32'(alumux2_rs2));
    for (int k = 0; k < 3; k++)
      run_vec("jal_stalled",    enc_j(5'd1, 20'hFFFFC),                       32'h200,   32'd0,        32'd0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1F8,     2'b01, 1'b1, 1'b0, 1'b1);
    run_vec("halt_in_reset",    enc_b(3'b000, 5'd0, 5'd0, 12'd0),             32'h300,   32'd0,        32'd0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300,     2'b01, 1'b0, 1'b0, 1'b0);
    run_vec("lui_after_reset",  32'h123450B7,                                 32'h100,   32'd1,        32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104,     2'b00, 1'b0, 1'b0, 1'b1);
    check_val("lui.regfilemux", 32'(bus.ctrl_o.regfilemux_sel), 32'(rf_u_imm));
    run_vec("store_sh",         enc_s(3'b001, 5'd2, 5'd3, 12'd8),             32'h100,   32'd1,        32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104,     2'b00, 1'b0, 1'b0, 1'b0);
    check_val("store_sh.byte_en", 32'(bus.ctrl_o.mem_byte_en), 32'h3);
    check_val("store_sh.mem_write", 32'(bus.ctrl_o.mem_write), 32'd1);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       r_f3 = 3'b000;
        1:       r_f3 = 3'b001;
        2:       r_f3 = 3'b101;
        default: r_f3 = 3'b111;
      endcase
      r_a    = $urandom;
      r_b    = ($urandom_range(0, 2) == 0) ? r_a : $urandom;
      r_pc   = $urandom & 32'hFFFF_FFFC;
      r_pred = 1'($urandom_range(0, 1));
      case (r_f3)
        3'b000:  r_tk = (r_a == r_b);
        3'b001:  r_tk = (r_a != r_b);
        3'b101:  r_tk = ($signed(r_a) >= $signed(r_b));
        default: r_tk = (r_a >= r_b);
      endcase
      r_tgt = r_tk ? r_pc + 32'd16 : r_pc + 32'd4;
      run_vec("rand_branch", enc_b(r_f3, 5'd3, 5'd4, 12'd8), r_pc, r_a, r_b, r_pred,
              1'b0, 1'b0, 1'b0, r_tk, r_tgt, r_tk ? 2'b01 : 2'b00, r_tk ^ r_pred, 1'b0, 1'b0);
    end

    // one more settled vector so the last branch's counter update is observed
    run_vec("final_nop",        32'h00000013,                                 32'h400,   32'd7,        32'd9,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h404,     2'b00, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
